fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register directly upstream of the opcode decoder / main control unit.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Registers the returned word and drives Inst_31_26 to the control unit.
- Takes resolved branch/jump decisions from decode to redirect the PC, flushing or buffering in-flight fetches.

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, req/ready imem handshake and branch/jump redirect.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the word already fetched on a taken redirect as a delay slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Data,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Branch_Not_Equal,
  input  logic        Jump,
  input  logic        Zero,
  input  logic [31:0] Branch_Offset,
  output logic [31:0] IFID_Inst,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid,
  output logic [5:0]  Inst_31_26
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic        kill, kill_nxt;
  logic        skid_valid, skid_valid_nxt;
  logic [31:0] skid_inst, skid_inst_nxt;
  logic [31:0] skid_pc4, skid_pc4_nxt;
  logic [31:0] ifid_inst, ifid_inst_nxt;
  logic [31:0] ifid_pc4, ifid_pc4_nxt;
  logic        ifid_valid, ifid_valid_nxt;

  logic        taken;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] target;
  logic [31:0] req_pc4;
`ifdef BRANCH_DELAY_SLOT_EN
  logic        slot_word;
`endif

  assign Imem_Req   = (state == FETCH);
  assign Imem_Addr  = req_addr;
  assign IFID_Inst  = ifid_inst;
  assign IFID_PC4   = ifid_pc4;
  assign IFID_Valid = ifid_valid;
  assign Inst_31_26 = ifid_valid ? ifid_inst[31:26] : 6'd0;

  assign taken         = ifid_valid & ~Stall &
                         (Jump | (Branch & Zero) | (Branch_Not_Equal & ~Zero));
  assign jump_target   = {ifid_pc4[31:28], ifid_inst[25:0], 2'b00};
  assign branch_target = ifid_pc4 + (Branch_Offset << 2);
  assign target        = Jump ? jump_target : branch_target;
  assign req_pc4       = req_addr + 32'd4;
`ifdef BRANCH_DELAY_SLOT_EN
  assign slot_word     = ((state == FETCH) & Imem_Ready & ~kill) |
                         ((state == HOLD) & skid_valid);
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      kill       <= 1'b0;
      skid_valid <= 1'b0;
      skid_inst  <= 32'd0;
      skid_pc4   <= 32'd0;
      ifid_inst  <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_addr   <= req_addr_nxt;
      kill       <= kill_nxt;
      skid_valid <= skid_valid_nxt;
      skid_inst  <= skid_inst_nxt;
      skid_pc4   <= skid_pc4_nxt;
      ifid_inst  <= ifid_inst_nxt;
      ifid_pc4   <= ifid_pc4_nxt;
      ifid_valid <= ifid_valid_nxt;
    end
  end

  // Decode consumes IF/ID every unstalled cycle, so it becomes a bubble unless a new word is loaded.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_addr_nxt   = req_addr;
    kill_nxt       = kill;
    skid_valid_nxt = skid_valid;
    skid_inst_nxt  = skid_inst;
    skid_pc4_nxt   = skid_pc4;
    ifid_inst_nxt  = ifid_inst;
    ifid_pc4_nxt   = ifid_pc4;
    ifid_valid_nxt = ifid_valid;

    if (!Stall) begin
      ifid_valid_nxt = 1'b0;
    end

    unique case (state)
      IDLE: begin
        state_nxt    = FETCH;
        req_addr_nxt = pc;
      end
      FETCH: begin
        if (Imem_Ready) begin
          if (kill) begin
            kill_nxt     = 1'b0;
            req_addr_nxt = pc;
          end else if (Stall) begin
            skid_valid_nxt = 1'b1;
            skid_inst_nxt  = Imem_Data;
            skid_pc4_nxt   = req_pc4;
            pc_nxt         = req_pc4;
            state_nxt      = HOLD;
          end else begin
            ifid_inst_nxt  = Imem_Data;
            ifid_pc4_nxt   = req_pc4;
            ifid_valid_nxt = 1'b1;
            pc_nxt         = req_pc4;
            req_addr_nxt   = req_pc4;
          end
        end
      end
      HOLD: begin
        if (!Stall) begin
          ifid_inst_nxt  = skid_inst;
          ifid_pc4_nxt   = skid_pc4;
          ifid_valid_nxt = 1'b1;
          skid_valid_nxt = 1'b0;
          state_nxt      = FETCH;
          req_addr_nxt   = pc;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A request still in flight cannot be cancelled on the bus, so its return is marked for discard.
    if (taken) begin
      pc_nxt         = target;
      skid_valid_nxt = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      if (!slot_word) begin
        ifid_valid_nxt = 1'b0;
        ifid_inst_nxt  = 32'd0;
      end
`else
      ifid_valid_nxt = 1'b0;
      ifid_inst_nxt  = 32'd0;
`endif
      if ((state == FETCH) && !Imem_Ready) begin
        kill_nxt = 1'b1;
      end else begin
        req_addr_nxt = target;
        state_nxt    = FETCH;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed redirect vectors, multi-cycle corner sequences
// and a randomized run checked against a program-order reference model.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ready;
  logic [31:0] Imem_Data;
  logic        Stall;
  logic        Branch;
  logic        Branch_Not_Equal;
  logic        Jump;
  logic        Zero;
  logic [31:0] Branch_Offset;
  logic [31:0] IFID_Inst;
  logic [31:0] IFID_PC4;
  logic        IFID_Valid;
  logic [5:0]  Inst_31_26;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .Imem_Req         (Imem_Req),
    .Imem_Addr        (Imem_Addr),
    .Imem_Ready       (Imem_Ready),
    .Imem_Data        (Imem_Data),
    .Stall            (Stall),
    .Branch           (Branch),
    .Branch_Not_Equal (Branch_Not_Equal),
    .Jump             (Jump),
    .Zero             (Zero),
    .Branch_Offset    (Branch_Offset),
    .IFID_Inst        (IFID_Inst),
    .IFID_PC4         (IFID_PC4),
    .IFID_Valid       (IFID_Valid),
    .Inst_31_26       (Inst_31_26)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        br;
    logic        bne;
    logic        j;
    logic        z;
    logic [31:0] off;
    logic [31:0] expAddr;
    logic        expValid;
  } vec_t;

  int          checks = 0;
  int          passes = 0;
  int          waitCnt = 0;
  int          curLat = 0;
  int          slowLat = 0;
  logic [31:0] slowAddr = 32'h0;
  bit          randMode = 1'b0;
  logic [31:0] progA [4];
  logic [31:0] progD [4];
  int          progN = 0;
  logic        reqS, rdyS;

  // Memory image: a few programmed words on top of an address hash.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    for (int i = 0; i < progN; i++)
      if (progA[i] == a) return progD[i];
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic st, input logic br, input logic bne, input logic j,
                               input logic z, input logic [31:0] off);
    Stall            = st;
    Branch           = br;
    Branch_Not_Equal = bne;
    Jump             = j;
    Zero             = z;
    Branch_Offset    = off;
  endtask

  task automatic driveMem();
    int lat;
    lat = randMode ? curLat : ((Imem_Addr == slowAddr) ? slowLat : 0);
    Imem_Ready = Imem_Req && (waitCnt >= lat);
    Imem_Data  = Imem_Ready ? memWord(Imem_Addr) : $urandom();
  endtask

  task automatic advance();
    reqS = Imem_Req;
    rdyS = Imem_Ready;
    @(posedge Clk);
    if (reqS && rdyS) begin
      waitCnt = 0;
      curLat  = $urandom_range(0, 3);
    end else if (reqS) begin
      waitCnt++;
    end
    @(negedge Clk);
    driveMem();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    Reset_n    = 1'b0;
    Imem_Ready = 1'b0;
    Imem_Data  = 32'd0;
    waitCnt    = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    driveMem();
  endtask

  task automatic runVector(input vec_t v);
    logic [31:0] w;
    progN    = 1;
    progA[0] = v.pc4 - 32'd4;
    progD[0] = v.inst;
    slowLat  = 0;
    doReset();
    for (int c = 0; c < 40 && !(IFID_Valid && IFID_PC4 == v.pc4); c++) advance();
    checkOutput("vec_reach_pc4", IFID_PC4, v.pc4);
    checkOutput("vec_reach_inst", IFID_Inst, v.inst);
    applyStimulus(1'b0, v.br, v.bne, v.j, v.z, v.off);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    w = memWord(v.pc4);
    checkOutput("vec_next_addr", Imem_Addr, v.expAddr);
    checkOutput("vec_valid", IFID_Valid, v.expValid);
    checkOutput("vec_opcode", Inst_31_26, v.expValid ? w[31:26] : 6'd0);
    if (v.expValid) checkOutput("vec_seq_pc4", IFID_PC4, v.pc4 + 32'd4);
  endtask

  initial begin
    vec_t        vecs [9];
    logic [31:0] w;
    logic [31:0] expPC, expPC4, prevAddr;
    logic        prevPend;
    logic        st, br, bne, j, z;
    logic [31:0] off;
    int          consumed;
    int          so;

    vecs[0] = '{32'h10, 32'h1000_0003, 1'b1, 1'b0, 1'b0, 1'b1, 32'd3,          32'h1C,        1'b0};
    vecs[1] = '{32'h10, 32'h1000_0003, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3,          32'h14,        1'b1};
    vecs[2] = '{32'h20, 32'h1400_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE,  32'h18,        1'b0};
    vecs[3] = '{32'h20, 32'h1400_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE,  32'h24,        1'b1};
    vecs[4] = '{32'h08, 32'h0800_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,          32'h100,       1'b0};
    vecs[5] = '{32'h0C, 32'h0800_0010, 1'b1, 1'b0, 1'b1, 1'b1, 32'd5,          32'h40,        1'b0};
    vecs[6] = '{32'h10, 32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_0000,  32'h10,        1'b0};
    vecs[7] = '{32'h18, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7,          32'h1C,        1'b1};
    vecs[8] = '{32'h10, 32'h1400_FFFB, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFB,  32'hFFFF_FFFC, 1'b0};

    // Reset values while held in reset.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    Reset_n = 1'b0;
    Imem_Ready = 1'b0;
    Imem_Data = 32'd0;
    #1;
    checkOutput("rst_req", Imem_Req, 1'b0);
    checkOutput("rst_addr", Imem_Addr, 32'h0);
    checkOutput("rst_inst", IFID_Inst, 32'h0);
    checkOutput("rst_pc4", IFID_PC4, 32'h0);
    checkOutput("rst_valid", IFID_Valid, 1'b0);
    checkOutput("rst_op", Inst_31_26, 6'd0);

    // Zero-wait first fetch after release.
    progN = 1; progA[0] = 32'h0; progD[0] = 32'h2008_0005;
    doReset();
    checkOutput("b_req_idle", Imem_Req, 1'b0);
    advance();
    checkOutput("b_req_rise", Imem_Req, 1'b1);
    checkOutput("b_addr0", Imem_Addr, 32'h0);
    advance();
    checkOutput("b_inst", IFID_Inst, 32'h2008_0005);
    checkOutput("b_pc4", IFID_PC4, 32'h4);
    checkOutput("b_valid", IFID_Valid, 1'b1);
    checkOutput("b_op", Inst_31_26, 6'd8);
    checkOutput("b_next_addr", Imem_Addr, 32'h4);

    // Three wait cycles at address 8.
    progN = 0; slowAddr = 32'h8; slowLat = 3;
    doReset();
    repeat (3) advance();
    for (int c = 0; c < 4; c++) begin
      checkOutput("c_addr_hold", Imem_Addr, 32'h8);
      checkOutput("c_req_hold", Imem_Req, 1'b1);
      if (c > 0) checkOutput("c_ifid_hold", IFID_PC4, 32'h8);
      advance();
    end
    checkOutput("c_pc4", IFID_PC4, 32'hC);
    checkOutput("c_inst", IFID_Inst, memWord(32'h8));
    checkOutput("c_valid", IFID_Valid, 1'b1);
    advance();
    checkOutput("c_once", IFID_PC4, 32'h10);

    // Stall in the ready cycle for two cycles: word parks in the skid buffer.
    slowLat = 0;
    doReset();
    repeat (2) advance();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    advance();
    checkOutput("d_req_hold1", Imem_Req, 1'b0);
    checkOutput("d_ifid_held", IFID_PC4, 32'h4);
    checkOutput("d_valid_held", IFID_Valid, 1'b1);
    advance();
    checkOutput("d_req_hold2", Imem_Req, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    advance();
    checkOutput("d_inst", IFID_Inst, memWord(32'h4));
    checkOutput("d_pc4", IFID_PC4, 32'h8);
    checkOutput("d_valid", IFID_Valid, 1'b1);
    checkOutput("d_resume_req", Imem_Req, 1'b1);
    checkOutput("d_resume_addr", Imem_Addr, 32'h8);

    // Jump while a two-cycle fetch is outstanding: returning word must be dropped.
    progN = 1; progA[0] = 32'h4; progD[0] = 32'h0800_0040;
    slowAddr = 32'h8; slowLat = 2;
    doReset();
    repeat (3) advance();
    checkOutput("e_jump_in_ifid", IFID_Inst, 32'h0800_0040);
    checkOutput("e_pending", Imem_Ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("e_flush_valid", IFID_Valid, 1'b0);
    checkOutput("e_addr_hold", Imem_Addr, 32'h8);
    advance();
    checkOutput("e_addr_hold2", Imem_Addr, 32'h8);
    advance();
    checkOutput("e_target_addr", Imem_Addr, 32'h100);
    checkOutput("e_dropped_valid", IFID_Valid, 1'b0);
    checkOutput("e_dropped_inst", IFID_Inst, 32'h0);
    advance();
    checkOutput("e_target_pc4", IFID_PC4, 32'h104);
    checkOutput("e_target_inst", IFID_Inst, memWord(32'h100));

    // Asynchronous reset in the middle of an outstanding request.
    progN = 0; slowAddr = 32'h8; slowLat = 3;
    doReset();
    repeat (3) advance();
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("f_req", Imem_Req, 1'b0);
    checkOutput("f_addr", Imem_Addr, 32'h0);
    checkOutput("f_inst", IFID_Inst, 32'h0);
    checkOutput("f_pc4", IFID_PC4, 32'h0);
    checkOutput("f_valid", IFID_Valid, 1'b0);
    checkOutput("f_op", Inst_31_26, 6'd0);
    waitCnt = 0;
    Imem_Ready = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    driveMem();
    advance();
    checkOutput("f_restart_addr", Imem_Addr, 32'h0);
    advance();
    checkOutput("f_restart_pc4", IFID_PC4, 32'h4);
    checkOutput("f_restart_inst", IFID_Inst, memWord(32'h0));

    // Redirect vectors; the last one lands at the top of memory to exercise PC wrap.
    slowLat = 0;
    for (int i = 0; i < 9; i++) runVector(vecs[i]);
    advance();
    checkOutput("wrap_pc4", IFID_PC4, 32'h0);
    checkOutput("wrap_inst", IFID_Inst, memWord(32'hFFFF_FFFC));
    checkOutput("wrap_addr", Imem_Addr, 32'h0);

    // Random run: every instruction decode consumes must follow architectural program order.
    randMode = 1'b1; progN = 0; slowLat = 0; curLat = 0;
    doReset();
    expPC = 32'h0; consumed = 0; prevPend = 1'b0; prevAddr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      advance();
      st  = ($urandom_range(0, 4) == 0);
      j   = ($urandom_range(0, 7) == 0);
      br  = ($urandom_range(0, 3) == 0);
      bne = ($urandom_range(0, 3) == 0);
      z   = $urandom_range(0, 1) == 1;
      so  = int'($urandom_range(0, 15)) - 8;
      off = ($urandom_range(0, 1) == 1) ? $urandom() : 32'(so);
      applyStimulus(st, br, bne, j, z, off);
      if (prevPend) begin
        checkOutput("rnd_req_hold", Imem_Req, 1'b1);
        checkOutput("rnd_addr_hold", Imem_Addr, prevAddr);
      end
      prevPend = Imem_Req && !Imem_Ready;
      prevAddr = Imem_Addr;
      if (IFID_Valid && !st) begin
        w = memWord(expPC);
        expPC4 = expPC + 32'd4;
        checkOutput("rnd_pc4", IFID_PC4, expPC4);
        checkOutput("rnd_inst", IFID_Inst, w);
        checkOutput("rnd_op", Inst_31_26, w[31:26]);
        if (j) expPC = {expPC4[31:28], w[25:0], 2'b00};
        else if ((br && z) || (bne && !z)) expPC = expPC4 + (off << 2);
        else expPC = expPC4;
        consumed++;
      end else if (!IFID_Valid) begin
        checkOutput("rnd_op_bubble", Inst_31_26, 6'd0);
      end
      if (checks - passes > 10) break;
    end
    checkOutput("rnd_progress", consumed > 200, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
